// File: rtl/hex_frame_sequencer.sv
// Shares one hex-to-seven-segment decoder across six HEX displays.
// A frame is scanned one nibble per cycle and then committed to all six displays at once.
module hex_frame_sequencer #(
  parameter logic [6:0] BLANK_CODE = 7'b1111111,
  parameter int unsigned MIN_DIGITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic [5:0]  in_blank,
  input  logic        lz_en,
  output logic [3:0]  dec_val,
  input  logic [6:0]  dec_leds,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] MIN_IDX = 3'(MIN_DIGITS);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state_q, state_d;
  logic [23:0] data_p0;
  logic [5:0]  blank_p0;
  logic        lz_p0;
  logic [2:0]  idx;
  logic        nz_seen;
  logic [6:0]  shadow [1:5];
  logic [6:0]  hex_q [6];
  logic        accept;
  logic        last;
  logic [3:0]  nibble;
  logic        blank_bit;
  logic        suppress;
  logic [6:0]  seg_d;

  function automatic logic [3:0] sel_nibble(input logic [23:0] d, input logic [2:0] i);
    logic [3:0] n;
    n = 4'h0;
    case (i)
      3'd0: n = d[3:0];
      3'd1: n = d[7:4];
      3'd2: n = d[11:8];
      3'd3: n = d[15:12];
      3'd4: n = d[19:16];
      3'd5: n = d[23:20];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  function automatic logic sel_blank(input logic [5:0] b, input logic [2:0] i);
    logic r;
    r = 1'b0;
    case (i)
      3'd0: r = b[0];
      3'd1: r = b[1];
      3'd2: r = b[2];
      3'd3: r = b[3];
      3'd4: r = b[4];
      3'd5: r = b[5];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        last = (idx == 3'd0);
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-digit decision: leading zeros count only nibble values, never the blank mask
  always_comb begin
    nibble    = sel_nibble(data_p0, idx);
    blank_bit = sel_blank(blank_p0, idx);
    suppress  = lz_p0 & ~nz_seen & (nibble == 4'h0) & (idx >= MIN_IDX);
    seg_d     = (blank_bit | suppress) ? BLANK_CODE : dec_leds;
    dec_val   = busy ? nibble : 4'h0;
  end

  // Frame capture stage: latched once per accepted frame, ignored during the scan
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0  <= in_data;
      blank_p0 <= in_blank;
      lz_p0    <= lz_en;
    end
  end

  // Scan stage: digits 5..1 park in shadow; digit 0 goes straight to the display with the rest
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx     <= 3'd5;
      nz_seen <= 1'b0;
      done    <= 1'b0;
      for (int i = 1; i < 6; i++) shadow[i] <= BLANK_CODE;
      for (int i = 0; i < 6; i++) hex_q[i] <= BLANK_CODE;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (accept) begin
        idx     <= 3'd5;
        nz_seen <= 1'b0;
      end else if (busy) begin
        for (int i = 1; i < 6; i++) begin
          if (idx == 3'(i)) shadow[i] <= seg_d;
        end
        nz_seen <= nz_seen | (nibble != 4'h0);
        idx     <= idx - 3'd1;
        if (last) begin
          hex_q[0] <= seg_d;
          for (int i = 1; i < 6; i++) hex_q[i] <= shadow[i];
          done <= 1'b1;
        end
      end
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_frame_sequencer.sv
// Bench for hex_frame_sequencer: a table decoder answers dec_val, and a
// frame-level model predicts the committed HEX5..HEX0 patterns.
module tb_hex_frame_sequencer;

  localparam int MIN_DIGITS = 1;
  localparam logic [6:0] BLK = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [5:0]  in_blank;
  logic        lz_en;
  logic [3:0]  dec_val;
  logic [6:0]  dec_leds;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic        busy;
  logic        done;
  logic [41:0] hex_obs;
  logic [41:0] exp_hex;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hex_frame_sequencer #(.BLANK_CODE(BLK), .MIN_DIGITS(MIN_DIGITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_blank(in_blank), .lz_en(lz_en),
    .dec_val(dec_val), .dec_leds(dec_leds),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .busy(busy), .done(done)
  );

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign dec_leds = seg7(dec_val);
  assign hex_obs  = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  // Digits above the most significant nonzero nibble are leading zeros
  function automatic logic [41:0] model(input logic [23:0] d, input logic [5:0] b, input logic lz);
    int top = -1;
    logic [41:0] r;
    for (int i = 0; i < 6; i++) if (d[4*i +: 4] != 4'h0) top = i;
    for (int i = 0; i < 6; i++) begin
      if (b[i] || (lz && i > top && i >= MIN_DIGITS)) r[7*i +: 7] = BLK;
      else r[7*i +: 7] = seg7(d[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; ends right after the commit edge
  task automatic scan_check(input logic [23:0] d, input logic [5:0] b, input logic lz,
                            input bit scramble, input string tag);
    logic [41:0] e;
    e = model(d, b, lz);
    for (int c = 0; c < 6; c++) begin
      vectors++;
      if (dec_val !== d[4*(5-c) +: 4]) begin
        miscompares++;
        $display("FAIL %s dec_val cycle %0d: got %h want %h", tag, c, dec_val, d[4*(5-c) +: 4]);
      end
      vectors++;
      if ({in_ready, busy, done} !== 3'b010) begin
        miscompares++;
        $display("FAIL %s scan ctrl cycle %0d: ready/busy/done got %b want 010", tag, c, {in_ready, busy, done});
      end
      vectors++;
      if (hex_obs !== exp_hex) begin
        miscompares++;
        $display("FAIL %s hex held cycle %0d: got %h want %h", tag, c, hex_obs, exp_hex);
      end
      if (scramble) begin
        in_valid = 1'($urandom);
        in_data  = 24'($urandom);
        in_blank = 6'($urandom);
        lz_en    = 1'($urandom);
      end
      step();
    end
    if (scramble) in_valid = 1'b0;
    exp_hex = e;
    vectors++;
    if ({in_ready, busy, done} !== 3'b101) begin
      miscompares++;
      $display("FAIL %s commit ctrl: ready/busy/done got %b want 101", tag, {in_ready, busy, done});
    end
    vectors++;
    if (hex_obs !== e) begin
      miscompares++;
      $display("FAIL %s commit hex: got %h want %h", tag, hex_obs, e);
    end
    vectors++;
    if (dec_val !== 4'h0) begin
      miscompares++;
      $display("FAIL %s idle dec_val: got %h want 0", tag, dec_val);
    end
  endtask

  task automatic run_frame(input logic [23:0] d, input logic [5:0] b, input logic lz, input string tag);
    in_data  = d;
    in_blank = b;
    lz_en    = lz;
    in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready before accept: got %b want 1", tag, in_ready);
    end
    step();
    in_valid = 1'b0;
    scan_check(d, b, lz, 1'b1, tag);
    step();
    vectors++;
    if (done !== 1'b0 || hex_obs !== exp_hex) begin
      miscompares++;
      $display("FAIL %s after done: done %b hex %h, want done 0 hex %h", tag, done, hex_obs, exp_hex);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 24'h0;
    in_blank = 6'h0;
    lz_en = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_hex = {6{BLK}};
    vectors++;
    if (hex_obs !== {6{BLK}}) begin
      miscompares++;
      $display("FAIL reset hex: got %h want %h", hex_obs, {6{BLK}});
    end
    vectors++;
    if ({in_ready, busy, done, dec_val} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset ctrl: ready/busy/done/dec_val got %b want 1000000", {in_ready, busy, done, dec_val});
    end
  endtask

  task automatic test_directed();
    run_frame(24'h012345, 6'b000000, 1'b0, "plain");
    run_frame(24'h000A0F, 6'b000000, 1'b1, "lz_interior");
    vectors++;
    if (HEX1 !== seg7(4'h0) || HEX2 !== seg7(4'hA) || HEX3 !== BLK) begin
      miscompares++;
      $display("FAIL lz_interior digits: HEX3..1 got %h %h %h", HEX3, HEX2, HEX1);
    end
    run_frame(24'h000000, 6'b000000, 1'b1, "zero_lz");
    vectors++;
    if (hex_obs !== {{5{BLK}}, seg7(4'h0)}) begin
      miscompares++;
      $display("FAIL zero_lz pattern: got %h want %h", hex_obs, {{5{BLK}}, seg7(4'h0)});
    end
    run_frame(24'h000000, 6'b000000, 1'b0, "zero_nolz");
    run_frame(24'hFFFFFF, 6'b101010, 1'b0, "blank_mask");
    run_frame(24'h00F000, 6'b001000, 1'b1, "blank_nonzero");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      logic [23:0] d;
      d = 24'($urandom);
      if (n % 3 == 0) d = d >> (4 * $urandom_range(0, 5));
      run_frame(d, 6'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] da, db;
    da = 24'h00ABCD;
    db = 24'h987000;
    in_data = da;
    in_blank = 6'b000000;
    lz_en = 1'b1;
    in_valid = 1'b1;
    step();
    in_data = db;
    in_blank = 6'b000001;
    lz_en = 1'b0;
    scan_check(da, 6'b000000, 1'b1, 1'b0, "b2b_A");
    step();
    in_valid = 1'b0;
    in_data = 24'h0;
    scan_check(db, 6'b000001, 1'b0, 1'b0, "b2b_B");
    step();
  endtask

  task automatic test_reset_midscan();
    in_data = 24'h123456;
    in_blank = 6'b000000;
    lz_en = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_hex = {6{BLK}};
    vectors++;
    if (hex_obs !== {6{BLK}} || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midscan reset: hex %h done %b, want %h done 0", hex_obs, done, {6{BLK}});
    end
    for (int c = 0; c < 7; c++) begin
      vectors++;
      if (in_ready !== 1'b1 || done !== 1'b0 || hex_obs !== {6{BLK}}) begin
        miscompares++;
        $display("FAIL midscan after reset cycle %0d: ready %b done %b hex %h", c, in_ready, done, hex_obs);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midscan();
    run_frame(24'h000100, 6'b000000, 1'b1, "post_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
